// File: rtl/riscv_mem_arbiter.sv
// Shares one main-memory block port among N_CH cache-miss FSMs.
// Requests are level-held until a one-cycle ready pulse. Arbitration is fixed-priority or round-robin.
module riscv_mem_arbiter #(
    parameter int N_CH       = 2,
    parameter int DATA_WIDTH = 128,
    parameter int S_ADDR     = 10,
    parameter int ARB_MODE   = 1,
    localparam int CH_W      = $clog2(N_CH)
) (
    input  logic                        i_riscv_arb_clk,
    input  logic                        i_riscv_arb_rst_n,
    input  logic [N_CH-1:0]             i_riscv_arb_ch_rden,
    input  logic [N_CH-1:0]             i_riscv_arb_ch_wren,
    input  logic [N_CH*S_ADDR-1:0]      i_riscv_arb_ch_addr,
    input  logic [N_CH*DATA_WIDTH-1:0]  i_riscv_arb_ch_wdata,
    output logic [N_CH-1:0]             o_riscv_arb_ch_ready,
    output logic [DATA_WIDTH-1:0]       o_riscv_arb_ch_rdata,
    output logic                        o_riscv_arb_mem_rden,
    output logic                        o_riscv_arb_mem_wren,
    output logic [S_ADDR-1:0]           o_riscv_arb_mem_addr,
    output logic [DATA_WIDTH-1:0]       o_riscv_arb_mem_wdata,
    input  logic                        i_riscv_arb_mem_ready,
    input  logic [DATA_WIDTH-1:0]       i_riscv_arb_mem_rdata,
    output logic                        o_riscv_arb_busy,
    output logic [31:0]                 o_riscv_arb_txn_count
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP, GAP} state_t;

    state_t                state;
    logic [CH_W-1:0]       ptr;
    logic [CH_W-1:0]       winner;
    logic [CH_W-1:0]       win;
    logic [CH_W-1:0]       idx;
    logic [CH_W-1:0]       nxt_ptr;
    logic [CH_W:0]         sum;
    logic                  found;
    logic [N_CH-1:0]       req;
    logic [S_ADDR-1:0]     addr_a  [N_CH];
    logic [DATA_WIDTH-1:0] wdata_a [N_CH];

    assign req = i_riscv_arb_ch_rden | i_riscv_arb_ch_wren;

    for (genvar g = 0; g < N_CH; g++) begin : g_unpack
        assign addr_a[g]  = i_riscv_arb_ch_addr[g*S_ADDR +: S_ADDR];
        assign wdata_a[g] = i_riscv_arb_ch_wdata[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Scan starts at the pointer (round-robin) or at channel 0 (fixed priority); first hit wins.
    always_comb begin
        win   = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int i = 0; i < N_CH; i++) begin
            idx = CH_W'(i);
            if (ARB_MODE != 0) begin
                sum = {1'b0, ptr} + (CH_W+1)'(i);
                if (sum >= (CH_W+1)'(N_CH)) sum = sum - (CH_W+1)'(N_CH);
                idx = sum[CH_W-1:0];
            end
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign nxt_ptr = (win == CH_W'(N_CH-1)) ? '0 : win + CH_W'(1);

    always_ff @(posedge i_riscv_arb_clk or negedge i_riscv_arb_rst_n) begin
        if (!i_riscv_arb_rst_n) begin
            state                 <= IDLE;
            ptr                   <= '0;
            winner                <= '0;
            o_riscv_arb_ch_ready  <= '0;
            o_riscv_arb_ch_rdata  <= '0;
            o_riscv_arb_mem_rden  <= 1'b0;
            o_riscv_arb_mem_wren  <= 1'b0;
            o_riscv_arb_mem_addr  <= '0;
            o_riscv_arb_mem_wdata <= '0;
            o_riscv_arb_busy      <= 1'b0;
            o_riscv_arb_txn_count <= '0;
        end else begin
            case (state)
                IDLE: if (found) begin
                    // Write wins when a channel raises both rden and wren.
                    winner                <= win;
                    o_riscv_arb_mem_addr  <= addr_a[win];
                    o_riscv_arb_mem_wdata <= wdata_a[win];
                    o_riscv_arb_mem_wren  <= i_riscv_arb_ch_wren[win];
                    o_riscv_arb_mem_rden  <= ~i_riscv_arb_ch_wren[win];
                    o_riscv_arb_busy      <= 1'b1;
                    if (ARB_MODE != 0) ptr <= nxt_ptr;
                    state                 <= BUSY;
                end
                BUSY: if (i_riscv_arb_mem_ready) begin
                    if (o_riscv_arb_mem_rden) o_riscv_arb_ch_rdata <= i_riscv_arb_mem_rdata;
                    o_riscv_arb_mem_rden         <= 1'b0;
                    o_riscv_arb_mem_wren         <= 1'b0;
                    o_riscv_arb_ch_ready[winner] <= 1'b1;
                    state                        <= RESP;
                end
                RESP: begin
                    o_riscv_arb_ch_ready  <= '0;
                    o_riscv_arb_txn_count <= o_riscv_arb_txn_count + 32'd1;
                    state                 <= GAP;
                end
                default: begin
                    // GAP lets the served requester drop its level before re-arbitration.
                    o_riscv_arb_busy <= 1'b0;
                    state            <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Scoreboard bench: a round-robin and a fixed-priority arbiter, each with a fixed-latency memory model.
// Stimulus pushes the expected completions; a monitor checks each ready pulse against the queue.
module tb_riscv_mem_arbiter;

    localparam int DW  = 128;
    localparam int SA  = 10;
    localparam int LAT = 5;

    typedef struct {
        int             d;
        int             ch;
        logic           wr;
        logic [SA-1:0]  a;
        logic [DW-1:0]  wd;
        logic [DW-1:0]  rd;
    } exp_t;

    logic clk;
    logic rst_n;
    logic [1:0]      rden   [2];
    logic [1:0]      wren   [2];
    logic [2*SA-1:0] addr   [2];
    logic [2*DW-1:0] wdata  [2];
    logic [1:0]      ready  [2];
    logic [DW-1:0]   rdata  [2];
    logic            mrd    [2];
    logic            mwr    [2];
    logic [SA-1:0]   maddr  [2];
    logic [DW-1:0]   mwdata [2];
    logic            mready [2] = '{default: 1'b0};
    logic [DW-1:0]   mrdata [2] = '{default: '0};
    logic            busy   [2];
    logic [31:0]     cnt    [2];

    logic [SA-1:0]   rec_addr  [2];
    logic            rec_wr    [2];
    logic            rec_rd    [2];
    logic [DW-1:0]   rec_wdata [2];
    int              lc        [2] = '{default: 0};

    exp_t       sbq [$];
    exp_t       e;
    logic [1:0] oh;
    int         ntest = 0;
    int         nfail = 0;
    int         cyc;

    riscv_mem_arbiter #(.N_CH(2), .DATA_WIDTH(DW), .S_ADDR(SA), .ARB_MODE(1)) u_rr (
        .i_riscv_arb_clk(clk), .i_riscv_arb_rst_n(rst_n),
        .i_riscv_arb_ch_rden(rden[0]), .i_riscv_arb_ch_wren(wren[0]),
        .i_riscv_arb_ch_addr(addr[0]), .i_riscv_arb_ch_wdata(wdata[0]),
        .o_riscv_arb_ch_ready(ready[0]), .o_riscv_arb_ch_rdata(rdata[0]),
        .o_riscv_arb_mem_rden(mrd[0]), .o_riscv_arb_mem_wren(mwr[0]),
        .o_riscv_arb_mem_addr(maddr[0]), .o_riscv_arb_mem_wdata(mwdata[0]),
        .i_riscv_arb_mem_ready(mready[0]), .i_riscv_arb_mem_rdata(mrdata[0]),
        .o_riscv_arb_busy(busy[0]), .o_riscv_arb_txn_count(cnt[0])
    );

    riscv_mem_arbiter #(.N_CH(2), .DATA_WIDTH(DW), .S_ADDR(SA), .ARB_MODE(0)) u_fp (
        .i_riscv_arb_clk(clk), .i_riscv_arb_rst_n(rst_n),
        .i_riscv_arb_ch_rden(rden[1]), .i_riscv_arb_ch_wren(wren[1]),
        .i_riscv_arb_ch_addr(addr[1]), .i_riscv_arb_ch_wdata(wdata[1]),
        .o_riscv_arb_ch_ready(ready[1]), .o_riscv_arb_ch_rdata(rdata[1]),
        .o_riscv_arb_mem_rden(mrd[1]), .o_riscv_arb_mem_wren(mwr[1]),
        .o_riscv_arb_mem_addr(maddr[1]), .o_riscv_arb_mem_wdata(mwdata[1]),
        .i_riscv_arb_mem_ready(mready[1]), .i_riscv_arb_mem_rdata(mrdata[1]),
        .o_riscv_arb_busy(busy[1]), .o_riscv_arb_txn_count(cnt[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mem_f(input logic [SA-1:0] a);
        return {4{32'hDEADBEEF ^ {22'h0, a}}};
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        ntest++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory answers LAT negedges after it first sees a request, for one cycle.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                lc[d]     = 0;
                mready[d] = 1'b0;
            end else if (mready[d]) begin
                mready[d] = 1'b0;
                lc[d]     = 0;
            end else if (mrd[d] || mwr[d]) begin
                lc[d]++;
                if (lc[d] == LAT) begin
                    mready[d]    = 1'b1;
                    mrdata[d]    = mem_f(maddr[d]);
                    rec_addr[d]  = maddr[d];
                    rec_wr[d]    = mwr[d];
                    rec_rd[d]    = mrd[d];
                    rec_wdata[d] = mwdata[d];
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (|ready[d]) begin
                if (sbq.size() == 0) begin
                    ntest++;
                    nfail++;
                    $display("FAIL unexpected_ready dut%0d: got %b expected none", d, ready[d]);
                end else begin
                    e  = sbq.pop_front();
                    oh = 2'b01 << e.ch;
                    chk("ready_dut", DW'(d), DW'(e.d));
                    chk("ready_onehot", DW'(ready[d]), DW'(oh));
                    chk("mem_addr", DW'(rec_addr[d]), DW'(e.a));
                    chk("mem_wren", DW'(rec_wr[d]), DW'(e.wr));
                    chk("mem_rden", DW'(rec_rd[d]), DW'(!e.wr));
                    if (e.wr) chk("mem_wdata", rec_wdata[d], e.wd);
                    chk("ch_rdata", rdata[d], e.rd);
                end
            end
        end
    end

    task automatic req(input int d, input int ch, input logic r, input logic w,
                       input logic [SA-1:0] a, input logic [DW-1:0] wd);
        rden[d][ch]               = r;
        wren[d][ch]               = w;
        addr[d][ch*SA +: SA]      = a;
        wdata[d][ch*DW +: DW]     = wd;
    endtask

    task automatic drop(input int d, input int ch);
        rden[d][ch] = 1'b0;
        wren[d][ch] = 1'b0;
    endtask

    task automatic push(input int d, input int ch, input logic w, input logic [SA-1:0] a,
                        input logic [DW-1:0] wd, input logic [DW-1:0] rd);
        exp_t x;
        x.d = d; x.ch = ch; x.wr = w; x.a = a; x.wd = wd; x.rd = rd;
        sbq.push_back(x);
    endtask

    task automatic wait_ready(input int d);
        int c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!(|ready[d]) && c < 100);
        if (!(|ready[d])) begin
            ntest++;
            nfail++;
            $display("FAIL ready_timeout dut%0d: got no ready in %0d cycles, expected a pulse", d, c);
        end
    endtask

    task automatic wait_idle(input int d);
        int c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (busy[d] && c < 100);
        if (busy[d]) begin
            ntest++;
            nfail++;
            $display("FAIL idle_timeout dut%0d: got busy=1 after %0d cycles, expected 0", d, c);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200000, expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 2; d++) begin
            rden[d] = '0; wren[d] = '0; addr[d] = '0; wdata[d] = '0;
        end
        repeat (3) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_busy", DW'(busy[d]), '0);
            chk("rst_mem_rden", DW'(mrd[d]), '0);
            chk("rst_ready", DW'(ready[d]), '0);
            chk("rst_txn_count", DW'(cnt[d]), '0);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Single read with latency check.
        req(0, 0, 1'b1, 1'b0, 10'h155, '0);
        push(0, 0, 1'b0, 10'h155, '0, 128'hDEADBFBA_DEADBFBA_DEADBFBA_DEADBFBA);
        @(negedge clk);
        chk("t1_mem_rden", DW'(mrd[0]), DW'(1'b1));
        chk("t1_mem_wren", DW'(mwr[0]), '0);
        chk("t1_mem_addr", DW'(maddr[0]), DW'(10'h155));
        chk("t1_busy", DW'(busy[0]), DW'(1'b1));
        cyc = 1;
        while (!(|ready[0]) && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        chk("t1_latency", DW'(cyc), DW'(6));
        drop(0, 0);
        @(negedge clk);
        chk("t1_txn_count", DW'(cnt[0]), DW'(1));
        wait_idle(0);

        // Write precedence: both enables on ch1, rdata must keep the previous read.
        @(negedge clk);
        req(0, 1, 1'b1, 1'b1, 10'h0AA, {16{8'hA5}});
        push(0, 1, 1'b1, 10'h0AA, {16{8'hA5}}, 128'hDEADBFBA_DEADBFBA_DEADBFBA_DEADBFBA);
        wait_ready(0);
        drop(0, 1);
        wait_idle(0);

        // Round-robin under continuous requests from both channels.
        req(0, 0, 1'b1, 1'b0, 10'h010, '0);
        req(0, 1, 1'b1, 1'b0, 10'h321, '0);
        for (int i = 0; i < 2; i++) begin
            push(0, 0, 1'b0, 10'h010, '0, mem_f(10'h010));
            push(0, 1, 1'b0, 10'h321, '0, mem_f(10'h321));
        end
        for (int i = 0; i < 4; i++) wait_ready(0);
        drop(0, 0);
        drop(0, 1);
        wait_idle(0);
        chk("t3_txn_count", DW'(cnt[0]), DW'(6));

        // ch0 drops right after grant and still completes; ch1 one-cycle pulse is never served.
        req(0, 0, 1'b1, 1'b0, 10'h200, '0);
        push(0, 0, 1'b0, 10'h200, '0, mem_f(10'h200));
        @(negedge clk);
        drop(0, 0);
        req(0, 1, 1'b1, 1'b0, 10'h111, '0);
        @(negedge clk);
        drop(0, 1);
        wait_ready(0);
        wait_idle(0);
        repeat (5) @(negedge clk);
        chk("t4_busy", DW'(busy[0]), '0);
        chk("t4_txn_count", DW'(cnt[0]), DW'(7));

        // Reset in BUSY; pointer returns to 0 so ch0 wins again afterwards.
        req(0, 0, 1'b1, 1'b0, 10'h0F0, '0);
        @(negedge clk);
        req(0, 1, 1'b1, 1'b0, 10'h033, '0);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_mem_rden", DW'(mrd[0]), '0);
        chk("t5_busy", DW'(busy[0]), '0);
        chk("t5_ready", DW'(ready[0]), '0);
        chk("t5_txn_count", DW'(cnt[0]), '0);
        chk("t5_ch_rdata", rdata[0], '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        push(0, 0, 1'b0, 10'h0F0, '0, mem_f(10'h0F0));
        push(0, 1, 1'b0, 10'h033, '0, mem_f(10'h033));
        wait_ready(0);
        drop(0, 0);
        wait_ready(0);
        drop(0, 1);
        wait_idle(0);
        chk("t5_txn_after", DW'(cnt[0]), DW'(2));

        // Fixed priority: ch0 held for two transactions starves ch1 until it drops.
        req(1, 0, 1'b1, 1'b0, 10'h001, '0);
        req(1, 1, 1'b1, 1'b0, 10'h002, '0);
        push(1, 0, 1'b0, 10'h001, '0, mem_f(10'h001));
        push(1, 0, 1'b0, 10'h001, '0, mem_f(10'h001));
        push(1, 1, 1'b0, 10'h002, '0, mem_f(10'h002));
        wait_ready(1);
        wait_ready(1);
        drop(1, 0);
        wait_ready(1);
        drop(1, 1);
        wait_idle(1);
        chk("t6_txn_count", DW'(cnt[1]), DW'(3));

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", DW'(sbq.size()), '0);
        $display("[TB] %0d tests run, %0d failed", ntest, nfail);
        $finish;
    end

endmodule

// File: doc/riscv_mem_arbiter.md
Name: riscv_mem_arbiter

Overview:
N-channel arbiter that lets several cache-miss FSMs (D-cache, I-cache, later DMA) share one main-memory port. It replaces the separate per-cache DRAM/IRAM model connections with a single memory model and is instantiated between the core's cache FSMs and that model. Each channel uses the existing cache-FSM protocol: request level held until a one-cycle ready pulse. Arbitration is round-robin or fixed-priority, selected by parameter, and a transaction counter supports performance work.

Parameters:
N_CH, 2, number of requester channels (>=2); channel 0 = D-cache, 1 = I-cache.
DATA_WIDTH, 128, block transfer width in bits.
S_ADDR, 10, block address width (ADDR - BYTE_OFF).
ARB_MODE, 1, 0 = fixed priority (lowest index wins), 1 = round-robin.
CH_W, $clog2(N_CH), derived grant-index width; not overridden.

Ports:
i_riscv_arb_clk  in  1  clock
i_riscv_arb_rst_n  in  1  asynchronous active-low reset
i_riscv_arb_ch_rden  in  N_CH  per-channel read request (level)
i_riscv_arb_ch_wren  in  N_CH  per-channel write request (level)
i_riscv_arb_ch_addr  in  N_CH*S_ADDR  flattened block addresses; channel k at [k*S_ADDR +: S_ADDR]
i_riscv_arb_ch_wdata  in  N_CH*DATA_WIDTH  flattened write blocks
o_riscv_arb_ch_ready  out  N_CH  per-channel completion pulse
o_riscv_arb_ch_rdata  out  DATA_WIDTH  read block shared by all channels; valid only with that channel's ready
o_riscv_arb_mem_rden  out  1  memory read request
o_riscv_arb_mem_wren  out  1  memory write request
o_riscv_arb_mem_addr  out  S_ADDR  memory block address
o_riscv_arb_mem_wdata  out  DATA_WIDTH  memory write block
i_riscv_arb_mem_ready  in  1  memory completion pulse
i_riscv_arb_mem_rdata  in  DATA_WIDTH  memory read block
o_riscv_arb_busy  out  1  high in any state other than IDLE
o_riscv_arb_txn_count  out  32  completed transactions; wraps modulo 2^32

Behaviour:
- Reset (asynchronous, rst_n=0) forces all of the following. Takes effect immediately, including mid-transaction; an in-flight memory access is abandoned.
  - State = IDLE.
  - All outputs 0.
  - Round-robin pointer = 0.
  - txn_count = 0.
- All outputs are registered.
- A channel is requesting when rden|wren. If wren and rden are both high, the channel is served as a write only.
- FSM states: IDLE, BUSY, RESP, GAP.
- IDLE: if any channel is requesting, pick a winner, go to BUSY, and register the winner's index, address and wdata. On the next cycle drive mem_rden or mem_wren (exactly one), mem_addr and mem_wdata. If no channel is requesting, stay in IDLE.
- Winner selection:
  - ARB_MODE=0: lowest requesting index.
  - ARB_MODE=1: first requesting index at or after the pointer, wrapping N_CH-1 -> 0. After a grant the pointer becomes (winner+1) mod N_CH.
- BUSY: hold the memory request stable. On mem_ready:
  - capture mem_rdata into ch_rdata (writes leave ch_rdata unchanged);
  - clear mem_rden/mem_wren;
  - set ch_ready[winner];
  - go to RESP.
- RESP: ch_ready[winner]=1 for exactly this cycle; txn_count increments by 1; go to GAP.
- GAP: one idle cycle so the requester can drop its request; requests are ignored; go to IDLE.
- Latency: request seen in IDLE at cycle 0 -> memory request visible at cycle 1 -> mem_ready at cycle k -> ch_ready visible at cycle k+1 -> earliest next memory request at cycle k+4.
- Dropped requests:
  - A request that drops before it is granted is never served.
  - A request that drops after its grant still completes and still pulses ready.
  - Input changes during BUSY do not alter the registered address or data.
- mem_ready outside BUSY is ignored.
- Requests are never lost while the arbiter is busy; pending channels are arbitrated at the next IDLE.
- ch_rdata holds its last value until the next read completes.

Test Plan:
- Single read: ch0 rden, addr=0x155, memory returns 0xDEAD_BEEF... at k=5 -> mem_rden=1 with addr 0x155 from cycle 1; ch_ready=01 at cycle 6 only, carrying rdata; txn_count=1.
- Round-robin (ARB_MODE=1): ch0 and ch1 request continuously from the same cycle -> grants alternate 0,1,0,1 over 4 transactions; no channel is served twice in a row.
- Fixed priority (ARB_MODE=0): ch0 and ch1 request together -> ch0 is served first, then ch1 once ch0 drops; with ch0 re-requesting in every GAP, ch1 waits, which is the documented behaviour.
- Write precedence: ch1 rden=1 and wren=1, wdata=0xA5 pattern -> only mem_wren is driven, with that wdata; ch_rdata keeps its previous value.
- Reset mid-op: assert rst_n=0 in BUSY -> mem_rden, ch_ready and busy drop to 0 immediately and txn_count=0; after release, a pending request is re-arbitrated from IDLE with pointer=0.
- Dropped request: ch1 pulses rden for one cycle while the arbiter serves ch0 -> ch1 is never granted; txn_count advances by 1 only.
